// File: rtl/dcache_wb_pkg.sv
// Shared types for the data cache: word type, controller states, line layout.
// No logic; no latency.
// Imported by the cache interface, the store-merge helper and the cache top.
package dcache_wb_pkg;

  typedef logic [31:0] word_t;

  // Default geometry; the line struct below is sized for it.
  localparam int DEF_NUM_SETS = 16;
  localparam int DEF_IDX_W    = $clog2(DEF_NUM_SETS);
  localparam int DEF_TAG_W    = 30 - DEF_IDX_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB      = 3'd1,
    S_FILL    = 3'd2,
    S_FLUSH   = 3'd3,
    S_FLUSHED = 3'd4
  } dcache_state_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [DEF_TAG_W-1:0] tag;
    word_t                data;
  } dcache_line_t;

endpackage

// File: rtl/dcache_wb_if.sv
// Datapath <-> data cache request interface.
// Ports: read, write[1:0], addr, store, done, halt (datapath -> cache); ready, load, flushed (cache -> datapath).
// Backpressure: the datapath holds its request stable until ready=1.
interface dcache_wb_if;
  import dcache_wb_pkg::*;

  logic       read;
  logic [1:0] write;
  word_t      addr;
  word_t      store;
  logic       done;
  logic       halt;
  logic       ready;
  word_t      load;
  logic       flushed;

  // master = datapath, slave = cache
  modport master (
    output read, write, addr, store, done, halt,
    input  ready, load, flushed
  );

  modport slave (
    input  read, write, addr, store, done, halt,
    output ready, load, flushed
  );
endinterface

// File: rtl/dcache_wb_store_merge.sv
// Little-endian byte/halfword/word lane merge of store data into an existing word.
// Purely combinational, zero latency; no handshake.
// Ports: i_old (current word), i_store, i_write (1=byte, 2=half, 3=word), i_off (addr[1:0]) -> o_word.
module dcache_wb_store_merge
  import dcache_wb_pkg::*;
(
  input  word_t      i_old,
  input  word_t      i_store,
  input  logic [1:0] i_write,
  input  logic [1:0] i_off,
  output word_t      o_word
);

  always_comb begin
    o_word = i_old;
    case (i_write)
      2'd1: begin
        case (i_off)
          2'd0:    o_word[7:0]   = i_store[7:0];
          2'd1:    o_word[15:8]  = i_store[7:0];
          2'd2:    o_word[23:16] = i_store[7:0];
          default: o_word[31:24] = i_store[7:0];
        endcase
      end
      // Halfword lane comes from addr[1] only; addr[0] is ignored.
      2'd2: begin
        if (i_off[1]) o_word[31:16] = i_store[15:0];
        else          o_word[15:0]  = i_store[15:0];
      end
      2'd3:    o_word = i_store;
      default: o_word = i_old;
    endcase
  end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache, one word per line; flushes dirty lines on halt.
// Latency: hit 0 cycles (combinational ready/load); miss 1 + mem latency (clean) or 2 + 2x mem latency (dirty).
// Backpressure: ready=0 while a miss or flush is in progress; memory requests held until mem_ready.
// Ports: clk, rst (async active-high), cif (slave side), mem_ren/mem_wen/mem_addr/mem_store out, mem_ready/mem_load in.
module dcache_wb
  import dcache_wb_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS
) (
  input  logic       clk,
  input  logic       rst,
  dcache_wb_if.slave cif,
  output logic       mem_ren,
  output logic       mem_wen,
  output word_t      mem_addr,
  output word_t      mem_store,
  input  logic       mem_ready,
  input  word_t      mem_load
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 30 - IDX_W;

  // Line storage: valid/dirty are reset, tag/data are not (valid=0 masks them).
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TAG_W-1:0]    r_tag  [NUM_SETS];
  word_t               r_data [NUM_SETS];

  dcache_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_cnt, w_cnt_nxt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_req;
  logic             w_hit;
  logic             w_wr_commit;
  logic             w_flush_last;
  word_t            w_merged;
  logic             w_ready;
  word_t            w_load;
  logic             w_flushed;

  assign w_idx = cif.addr[IDX_W+1:2];
  assign w_tag = cif.addr[31:IDX_W+2];
  assign w_req = cif.read | (|cif.write);
  // halt outranks requests, so a hit is never reported while halt is up.
  assign w_hit = (r_state == S_IDLE) && !cif.halt && w_req &&
                 r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wr_commit  = w_hit && (|cif.write) && cif.done;
  assign w_flush_last = (r_cnt == IDX_W'(NUM_SETS - 1));

  dcache_wb_store_merge u_merge (
    .i_old   (r_data[w_idx]),
    .i_store (cif.store),
    .i_write (cif.write),
    .i_off   (cif.addr[1:0]),
    .o_word  (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_store   = '0;
    w_ready     = 1'b0;
    w_load      = '0;
    w_flushed   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cif.halt) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = '0;
        end else if (w_hit) begin
          w_ready = 1'b1;
          w_load  = r_data[w_idx];
        end else if (w_req) begin
          w_state_nxt = r_dirty[w_idx] ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        mem_wen   = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx, 2'b00};
        mem_store = r_data[w_idx];
        if (mem_ready) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        mem_ren  = 1'b1;
        mem_addr = {cif.addr[31:2], 2'b00};
        if (mem_ready) w_state_nxt = S_IDLE;
      end
      S_FLUSH: begin
        // Clean sets cost one cycle; dirty sets wait for their write-back.
        if (!r_dirty[r_cnt] || mem_ready) begin
          if (w_flush_last) w_state_nxt = S_FLUSHED;
          else              w_cnt_nxt   = r_cnt + 1'b1;
        end
        if (r_dirty[r_cnt]) begin
          mem_wen   = 1'b1;
          mem_addr  = {r_tag[r_cnt], r_cnt, 2'b00};
          mem_store = r_data[r_cnt];
        end
      end
      S_FLUSHED: w_flushed = 1'b1;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  assign cif.ready   = w_ready;
  assign cif.load    = w_load;
  assign cif.flushed = w_flushed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (r_state == S_FILL && mem_ready) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      if (w_wr_commit) r_dirty[w_idx] <= 1'b1;
      if (r_state == S_FLUSH && mem_ready && r_dirty[r_cnt]) r_dirty[r_cnt] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FILL && mem_ready) begin
      r_tag[w_idx]  <= w_tag;
      r_data[w_idx] <= mem_load;
    end else if (w_wr_commit) begin
      r_data[w_idx] <= w_merged;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb with a latency-3 word memory model and transaction log.
// Inputs driven on the falling edge; outputs sampled 1 time unit later.
// Memory model pulses mem_ready for one cycle once a request has been seen on 3 falling edges.
module tb_dcache_wb;
  import dcache_wb_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  logic  mem_ren, mem_wen, mem_ready;
  word_t mem_addr, mem_store, mem_load;

  dcache_wb_if cif();

  dcache_wb #(.NUM_SETS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cif       (cif),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_store (mem_store),
    .mem_ready (mem_ready),
    .mem_load  (mem_load)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  word_t mem_arr [word_t];
  int    mem_lat   = 3;
  int    wait_cnt  = 0;
  int    proto_err = 0;
  logic  prev_act  = 1'b0;
  word_t prev_addr = '0;
  logic  tx_wr   [$];
  word_t tx_addr [$];
  word_t tx_data [$];

  // Memory model plus protocol monitor (exclusive ren/wen, address held until ready).
  initial begin
    mem_ready = 1'b0;
    mem_load  = '0;
    forever begin
      @(negedge clk);
      if (mem_ready || rst) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
        prev_act  = 1'b0;
      end else if (mem_ren || mem_wen) begin
        if (mem_ren && mem_wen) proto_err++;
        if (prev_act && mem_addr !== prev_addr) proto_err++;
        prev_act  = 1'b1;
        prev_addr = mem_addr;
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          tx_wr.push_back(mem_wen);
          tx_addr.push_back(mem_addr);
          if (mem_wen) begin
            mem_arr[mem_addr] = mem_store;
            tx_data.push_back(mem_store);
            mem_load = '0;
          end else begin
            mem_load = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
            tx_data.push_back(mem_load);
          end
        end
      end else begin
        wait_cnt = 0;
        prev_act = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called on a falling edge; returns on the falling edge after the accepting cycle.
  task automatic access(input logic rd, input logic [1:0] wr, input word_t a, input word_t st,
                        output word_t ld, output int cyc);
    cyc = 0;
    cif.read = rd; cif.write = wr; cif.addr = a; cif.store = st; cif.done = 1'b1;
    #1;
    while (!cif.ready && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 100) begin
      failures++;
      $display("FAIL access_timeout addr=%h got no ready within %0d cycles", a, cyc);
    end
    ld = cif.load;
    @(negedge clk);
    cif.read = 1'b0; cif.write = 2'd0; cif.addr = '0; cif.store = '0; cif.done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cif.read = 1'b0; cif.write = 2'd0; cif.addr = '0; cif.store = '0;
    cif.done = 1'b0; cif.halt = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({cif.ready, cif.flushed, mem_ren, mem_wen} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got %b want 0000", {cif.ready, cif.flushed, mem_ren, mem_wen});
    end
    checks++;
    if (cif.load !== 32'h0) begin
      failures++; $display("FAIL reset_load got %h want 0", cif.load);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_store !== 32'h0) begin
      failures++; $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_addr, mem_store);
    end
    @(negedge clk);
  endtask

  task automatic test_cold_read();
    word_t ld; int cyc; int n0;
    mem_arr[32'h40] = 32'hDEADBEEF;
    n0 = tx_wr.size();
    access(1'b1, 2'd0, 32'h40, 32'h0, ld, cyc);
    checks++;
    if (ld !== 32'hDEADBEEF) begin failures++; $display("FAIL cold_load got %h want deadbeef", ld); end
    checks++;
    if (cyc !== 4) begin failures++; $display("FAIL cold_latency got %0d want 4", cyc); end
    checks++;
    if (tx_wr.size() != n0 + 1 || tx_wr[n0] !== 1'b0 || tx_addr[n0] !== 32'h40) begin
      failures++; $display("FAIL cold_traffic got %0d txns want one read at 40", tx_wr.size() - n0);
    end
    access(1'b1, 2'd0, 32'h40, 32'h0, ld, cyc);
    checks++;
    if (ld !== 32'hDEADBEEF || cyc !== 0 || tx_wr.size() != n0 + 1) begin
      failures++; $display("FAIL reread_hit got %h cyc=%0d txns=%0d want deadbeef 0 1", ld, cyc, tx_wr.size() - n0);
    end
  endtask

  task automatic test_write_byte();
    word_t ld; int cyc; int n0;
    n0 = tx_wr.size();
    access(1'b0, 2'd1, 32'h41, 32'h000000AB, ld, cyc);
    checks++;
    if (cyc !== 0 || ld !== 32'hDEADBEEF) begin
      failures++; $display("FAIL byte_write_hit got cyc=%0d load=%h want 0 deadbeef", cyc, ld);
    end
    access(1'b1, 2'd0, 32'h40, 32'h0, ld, cyc);
    checks++;
    if (ld !== 32'hDEADABEF || tx_wr.size() != n0) begin
      failures++; $display("FAIL byte_write_data got %h txns=%0d want deadabef 0", ld, tx_wr.size() - n0);
    end
  endtask

  task automatic test_dirty_evict();
    word_t ld; int cyc; int n0;
    mem_arr[32'h80] = 32'h11223344;
    n0 = tx_wr.size();
    access(1'b1, 2'd0, 32'h80, 32'h0, ld, cyc);
    checks++;
    if (cyc !== 8) begin failures++; $display("FAIL evict_latency got %0d want 8", cyc); end
    checks++;
    if (tx_wr.size() != n0 + 2 || tx_wr[n0] !== 1'b1 || tx_addr[n0] !== 32'h40 ||
        tx_data[n0] !== 32'hDEADABEF) begin
      failures++; $display("FAIL evict_writeback got %0d txns want write 40=deadabef first", tx_wr.size() - n0);
    end
    checks++;
    if (tx_wr.size() != n0 + 2 || tx_wr[n0+1] !== 1'b0 || tx_addr[n0+1] !== 32'h80) begin
      failures++; $display("FAIL evict_fill got %0d txns want read 80 second", tx_wr.size() - n0);
    end
    checks++;
    if (ld !== 32'h11223344) begin failures++; $display("FAIL evict_load got %h want 11223344", ld); end
  endtask

  task automatic test_lanes();
    word_t ld; int cyc;
    word_t wa [4]   = '{32'h106, 32'h107, 32'h105, 32'h107};
    logic [1:0] wm [4] = '{2'd2, 2'd3, 2'd2, 2'd1};
    word_t ws [4]   = '{32'h1234, 32'hCAFEF00D, 32'hFFFF5678, 32'h000000EE};
    word_t exp [4]  = '{32'h12340000, 32'hCAFEF00D, 32'hCAFE5678, 32'hEEFE5678};
    for (int i = 0; i < 4; i++) begin
      // Word write also sets read, which must behave as a write.
      access(i == 1, wm[i], wa[i], ws[i], ld, cyc);
      if (i == 0) begin
        checks++;
        if (cyc !== 4 || ld !== 32'h0) begin
          failures++; $display("FAIL lane_miss_write got cyc=%0d load=%h want 4 0", cyc, ld);
        end
      end
      access(1'b1, 2'd0, 32'h104, 32'h0, ld, cyc);
      checks++;
      if (ld !== exp[i]) begin
        failures++; $display("FAIL lane_merge_%0d got %h want %h", i, ld, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    word_t ld; int cyc; int n0;
    mem_arr[32'h200] = 32'h5A5A5A5A;
    cif.read = 1'b1; cif.addr = 32'h200; cif.done = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (mem_ren !== 1'b1) begin failures++; $display("FAIL fill_started got ren=%b want 1", mem_ren); end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || cif.ready !== 1'b0) begin
      failures++; $display("FAIL reset_drops_fill got ren=%b wen=%b rdy=%b want 0 0 0", mem_ren, mem_wen, cif.ready);
    end
    cif.read = 1'b0; cif.addr = '0; cif.done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n0 = tx_wr.size();
    access(1'b1, 2'd0, 32'h200, 32'h0, ld, cyc);
    checks++;
    if (cyc !== 4 || tx_wr.size() != n0 + 1 || ld !== 32'h5A5A5A5A) begin
      failures++; $display("FAIL post_reset_miss got cyc=%0d txns=%0d load=%h want 4 1 5a5a5a5a", cyc, tx_wr.size() - n0, ld);
    end
  endtask

  task automatic test_flush();
    word_t ld; int cyc; int n0;
    access(1'b0, 2'd3, 32'h08, 32'h22222222, ld, cyc);
    access(1'b0, 2'd3, 32'h24, 32'h99999999, ld, cyc);
    n0 = tx_wr.size();
    cif.halt = 1'b1;
    cyc = 0;
    #1;
    while (!cif.flushed && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 21) begin failures++; $display("FAIL flush_cycles got %0d want 21", cyc); end
    checks++;
    if (tx_wr.size() != n0 + 2 || tx_wr[n0] !== 1'b1 || tx_addr[n0] !== 32'h08 ||
        tx_data[n0] !== 32'h22222222) begin
      failures++; $display("FAIL flush_first got %0d txns want write 08=22222222 first", tx_wr.size() - n0);
    end
    checks++;
    if (tx_wr.size() != n0 + 2 || tx_wr[n0+1] !== 1'b1 || tx_addr[n0+1] !== 32'h24 ||
        tx_data[n0+1] !== 32'h99999999) begin
      failures++; $display("FAIL flush_second got %0d txns want write 24=99999999 second", tx_wr.size() - n0);
    end
    @(negedge clk);
    cif.halt = 1'b0; cif.read = 1'b1; cif.addr = 32'h08;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (cif.flushed !== 1'b1 || cif.ready !== 1'b0 || mem_ren !== 1'b0 ||
        mem_wen !== 1'b0 || tx_wr.size() != n0 + 2) begin
      failures++; $display("FAIL flushed_sticky got fl=%b rdy=%b ren=%b wen=%b txns=%0d want 1 0 0 0 2",
                           cif.flushed, cif.ready, mem_ren, mem_wen, tx_wr.size() - n0);
    end
    cif.read = 1'b0; cif.addr = '0;
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_err !== 0) begin failures++; $display("FAIL mem_protocol got %0d violations want 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_byte();
    test_dirty_evict();
    test_lanes();
    test_reset_mid_fill();
    test_flush();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
